// File: rtl/cnt4b_ctrl_panel_pkg.sv
// Shared definitions for the counter control panel: FSM state codes,
// mode encodings and default sizing.
package cnt4b_ctrl_panel_pkg;

  // Panel FSM states; the encoding is visible on state_o for the LEDs.
  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_MAX = 2'd3
  } state_t;

  // Counter direction as seen on mode_o.
  localparam logic MODE_UP = 1'b1;
  localparam logic MODE_DN = 1'b0;

  // Default sizing for a 50 MHz board with a 1 Hz count step.
  localparam int W_DEF         = 4;
  localparam int DB_CYCLES_DEF = 500000;
  localparam int TICK_DIV_DEF  = 50000000;

  // Flip the counting direction.
  function automatic logic toggle_mode(input logic mode);
    return (mode == MODE_UP) ? MODE_DN : MODE_UP;
  endfunction

endpackage

// File: rtl/cnt4b_ctrl_panel_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debounce counter
// and a registered one-cycle pulse on every accepted press (rising level).
module btn_debounce
  import cnt4b_ctrl_panel_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;

  // Synchronise, accept a new level only after DB_CYCLES differing samples
  // in a row (any bounce restarts the count), then edge-detect the level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/cnt4b_ctrl_panel.sv
// Control panel in front of the 4-bit up/down counter: debounced buttons,
// run/stop/set FSM, MIN/MAX/mode registers, step tick and reload pulse.
module cnt4b_ctrl_panel
  import cnt4b_ctrl_panel_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_ss,
  input  logic         btn_mode,
  input  logic         btn_set,
  input  logic [W-1:0] sw,
  output logic         cnt_rst_o,
  output logic         ss_o,
  output logic         mode_o,
  output logic [W-1:0] min_o,
  output logic [W-1:0] max_o,
  output logic [1:0]   state_o
);

  localparam int DW = $clog2(TICK_DIV);

  logic w_ss_level, w_ss_press;
  logic w_mode_level, w_mode_press;
  logic w_set_level, w_set_press;
  logic w_set_act, w_ss_act, w_mode_act;
  logic w_tick;
  logic w_reload;

  state_t        r_state;
  logic          r_mode;
  logic [W-1:0]  r_min;
  logic [W-1:0]  r_max;
  logic [W-1:0]  r_sw_s1;
  logic [W-1:0]  r_sw_s2;
  logic [DW-1:0] r_div;
  logic          r_cnt_rst;
  logic          r_ss;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_ss),
    .level (w_ss_level),
    .press (w_ss_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .level (w_mode_level),
    .press (w_mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_set),
    .level (w_set_level),
    .press (w_set_press)
  );

  // A press is honoured only while its debounced level still reads pressed.
  // Priority set > ss > mode; losers in the same cycle are dropped.
  assign w_set_act  = w_set_press & w_set_level;
  assign w_ss_act   = w_ss_press & w_ss_level & ~w_set_act;
  assign w_mode_act = w_mode_press & w_mode_level & ~w_set_act & ~w_ss_act;

  assign w_tick = (r_div == DW'(TICK_DIV - 1));

  // Decide whether this cycle's transition must reload the counter.
  always_comb begin
    w_reload = 1'b0;
    case (r_state)
      ST_STOP, ST_RUN: w_reload = w_set_act | w_mode_act;
      ST_SET_MIN:      w_reload = 1'b0;
      ST_SET_MAX:      w_reload = w_set_act;
      default:         w_reload = 1'b0;
    endcase
  end

  // Panel FSM with its data registers, step divider and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_STOP;
      r_mode    <= MODE_UP;
      r_min     <= '0;
      r_max     <= '1;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_div     <= '0;
      r_cnt_rst <= 1'b1;
      r_ss      <= 1'b0;
    end else begin
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
      r_cnt_rst <= w_reload;
      // A step never coincides with a reload, so the counter sees a clean load.
      r_ss      <= w_tick & (r_state == ST_RUN) & ~w_reload;
      r_div     <= w_tick ? '0 : r_div + DW'(1);
      case (r_state)
        ST_STOP: begin
          if (w_set_act) begin
            r_state <= ST_SET_MIN;
          end else if (w_ss_act) begin
            r_state <= ST_RUN;
            // Restart the divider so the first step lands a full period later.
            r_div   <= '0;
          end else if (w_mode_act) begin
            r_mode <= toggle_mode(r_mode);
          end
        end
        ST_RUN: begin
          if (w_set_act) begin
            r_state <= ST_SET_MIN;
          end else if (w_ss_act) begin
            r_state <= ST_STOP;
          end else if (w_mode_act) begin
            r_mode <= toggle_mode(r_mode);
          end
        end
        ST_SET_MIN: begin
          if (w_set_act) begin
            r_min   <= r_sw_s2;
            r_state <= ST_SET_MAX;
          end
        end
        ST_SET_MAX: begin
          if (w_set_act) begin
            // Keep MIN <= MAX by swapping when entered out of order.
            if (r_min > r_sw_s2) begin
              r_min <= r_sw_s2;
              r_max <= r_min;
            end else begin
              r_max <= r_sw_s2;
            end
            r_state <= ST_STOP;
          end
        end
        default: r_state <= ST_STOP;
      endcase
    end
  end

  assign cnt_rst_o = r_cnt_rst;
  assign ss_o      = r_ss;
  assign mode_o    = r_mode;
  assign min_o     = r_min;
  assign max_o     = r_max;
  assign state_o   = r_state;

endmodule

// File: tb/tb_cnt4b_ctrl_panel.sv
// Scoreboard bench for cnt4b_ctrl_panel (W=4, DB_CYCLES=4, TICK_DIV=5).
// Stimulus queues every expected change of the output tuple with the cycle it
// must appear on; the monitor pops one entry whenever the outputs change.
module tb_cnt4b_ctrl_panel;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int TD = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn_ss = 1'b0;
  logic         btn_mode = 1'b0;
  logic         btn_set = 1'b0;
  logic [W-1:0] sw = 4'd0;
  logic         cnt_rst_o;
  logic         ss_o;
  logic         mode_o;
  logic [W-1:0] min_o;
  logic [W-1:0] max_o;
  logic [1:0]   state_o;

  cnt4b_ctrl_panel #(.W(W), .DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_ss    (btn_ss),
    .btn_mode  (btn_mode),
    .btn_set   (btn_set),
    .sw        (sw),
    .cnt_rst_o (cnt_rst_o),
    .ss_o      (ss_o),
    .mode_o    (mode_o),
    .min_o     (min_o),
    .max_o     (max_o),
    .state_o   (state_o)
  );

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       mode;
    logic [3:0] mn;
    logic [3:0] mx;
    logic       ss;
    logic       crst;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  // Current expected register contents used when queuing events.
  logic [1:0] e_st;
  logic       e_mode;
  logic [3:0] e_min;
  logic [3:0] e_max;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic exp_ev(input int at, input logic ss, input logic crst);
    ev_t e;
    e.cyc = at; e.st = e_st; e.mode = e_mode; e.mn = e_min; e.mx = e_max;
    e.ss = ss; e.crst = crst;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m = {set, mode, ss}: hold 8 cycles, release, allow 10 cycles to settle.
  task automatic press(input logic [2:0] m);
    btn_ss = m[0]; btn_mode = m[1]; btn_set = m[2];
    tick(8);
    btn_ss = 1'b0; btn_mode = 1'b0; btn_set = 1'b0;
    tick(10);
  endtask

  // Monitor: on every change of the output tuple, pop and compare.
  initial begin
    logic [12:0] prev;
    logic [12:0] cur;
    bit          have;
    ev_t         e;
    have = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {state_o, mode_o, min_o, max_o, ss_o, cnt_rst_o};
        if (!have || cur !== prev) begin
          have = 1'b1;
          prev = cur;
          n_checks++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change cyc=%0d got st=%0d mode=%0b min=%0d max=%0d ss=%0b crst=%0b",
                     cyc, state_o, mode_o, min_o, max_o, ss_o, cnt_rst_o);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || state_o !== e.st || mode_o !== e.mode || min_o !== e.mn ||
                max_o !== e.mx || ss_o !== e.ss || cnt_rst_o !== e.crst) begin
              n_fail++;
              $display("FAIL event got cyc=%0d st=%0d mode=%0b min=%0d max=%0d ss=%0b crst=%0b required cyc=%0d st=%0d mode=%0b min=%0d max=%0d ss=%0b crst=%0b",
                       cyc, state_o, mode_o, min_o, max_o, ss_o, cnt_rst_o,
                       e.cyc, e.st, e.mode, e.mn, e.mx, e.ss, e.crst);
            end
          end
        end
      end
    end
  end

  initial begin
    int b;
    // 1. Reset for cycles 1..3, released after edge 3.
    rst = 1'b1;
    tick(1);
    e_st = 2'd0; e_mode = 1'b1; e_min = 4'd0; e_max = 4'd15;
    exp_ev(1, 1'b0, 1'b1);
    exp_ev(4, 1'b0, 1'b0);
    mon_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);

    // 2. ss held 10 cycles: press at b+7, RUN at b+8, steps at b+13+5k.
    //    Re-press at b+22 -> STOP at b+30.
    b = cyc;
    e_st = 2'd1;
    exp_ev(b + 8, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_ev(b + 13 + 5 * k, 1'b1, 1'b0);
      exp_ev(b + 14 + 5 * k, 1'b0, 1'b0);
    end
    e_st = 2'd0;
    exp_ev(b + 30, 1'b0, 1'b0);
    btn_ss = 1'b1; tick(10);
    btn_ss = 1'b0; tick(12);
    btn_ss = 1'b1; tick(10);
    btn_ss = 1'b0; tick(13);

    // 3. Bouncing ss (2 high / 2 low for 20 cycles): no change expected.
    for (int k = 0; k < 5; k++) begin
      btn_ss = 1'b1; tick(2);
      btn_ss = 1'b0; tick(2);
    end
    tick(15);

    // 4. Entry 9 then 3: swapped to min=3, max=9; reload on SET_MIN entry and SET_MAX exit.
    b = cyc;
    e_st = 2'd2; exp_ev(b + 8, 1'b0, 1'b1); exp_ev(b + 9, 1'b0, 1'b0);
    e_st = 2'd3; e_min = 4'd9; exp_ev(b + 26, 1'b0, 1'b0);
    e_st = 2'd0; e_min = 4'd3; e_max = 4'd9;
    exp_ev(b + 44, 1'b0, 1'b1); exp_ev(b + 45, 1'b0, 1'b0);
    sw = 4'd9;
    press(3'b100);
    press(3'b100);
    sw = 4'd3;
    press(3'b100);

    // 5. RUN, then ss+mode in the same cycle: only ss acts, no reload.
    b = cyc;
    e_st = 2'd1; exp_ev(b + 8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_ev(b + 13 + 5 * k, 1'b1, 1'b0);
      exp_ev(b + 14 + 5 * k, 1'b0, 1'b0);
    end
    e_st = 2'd0; exp_ev(b + 26, 1'b0, 1'b0);
    press(3'b001);
    press(3'b011);
    tick(10);

    // Mode press in STOP: mode -> down with a one-cycle reload.
    b = cyc;
    e_mode = 1'b0; exp_ev(b + 8, 1'b0, 1'b1); exp_ev(b + 9, 1'b0, 1'b0);
    press(3'b010);

    // 6. Reset while in SET_MAX (min=5 latched, sw=7): defaults restored.
    b = cyc;
    sw = 4'd5;
    e_st = 2'd2; exp_ev(b + 8, 1'b0, 1'b1); exp_ev(b + 9, 1'b0, 1'b0);
    e_st = 2'd3; e_min = 4'd5; exp_ev(b + 26, 1'b0, 1'b0);
    e_st = 2'd0; e_mode = 1'b1; e_min = 4'd0; e_max = 4'd15;
    exp_ev(b + 37, 1'b0, 1'b1); exp_ev(b + 39, 1'b0, 1'b0);
    press(3'b100);
    press(3'b100);
    sw = 4'd7;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);

    // Fresh entry with min == max == 7: no swap, single-value range.
    b = cyc;
    e_st = 2'd2; exp_ev(b + 8, 1'b0, 1'b1); exp_ev(b + 9, 1'b0, 1'b0);
    e_st = 2'd3; e_min = 4'd7; exp_ev(b + 26, 1'b0, 1'b0);
    e_st = 2'd0; e_max = 4'd7;
    exp_ev(b + 44, 1'b0, 1'b1); exp_ev(b + 45, 1'b0, 1'b0);
    press(3'b100);
    press(3'b100);
    press(3'b100);
    tick(10);

    // Every queued event must have been observed.
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events got %0d left required 0 (next at cyc=%0d)", q.size(), q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
